// File: rtl/pci_single_initiator.sv
// Single-data-phase 32-bit PCI memory initiator: one local request becomes one
// arbitrated PCI transaction with retry, master-abort and target-abort handling.
module pci_single_initiator #(
  parameter int unsigned MAX_RETRY      = 16,
  parameter int unsigned DEVSEL_TIMEOUT = 5
) (
  input  logic        PCI_CLK,
  input  logic        PCI_RSTn,
  output logic        PCI_REQn,
  input  logic        PCI_GNTn,
  input  logic        PCI_FRAMEn_i,
  input  logic        PCI_IRDYn_i,
  output logic        PCI_FRAMEn_o,
  output logic        PCI_IRDYn_o,
  output logic        PCI_CTLoe,
  input  logic        PCI_TRDYn,
  input  logic        PCI_STOPn,
  input  logic        PCI_DEVSELn,
  input  logic [31:0] PCI_AD_i,
  output logic [31:0] PCI_AD_o,
  output logic        PCI_ADoe,
  output logic [3:0]  PCI_CBE_o,
  output logic        PCI_CBEoe,
  output logic        PCI_PAR_o,
  output logic        PCI_PARoe,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status
);

  localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DCW = (DEVSEL_TIMEOUT > 1) ? $clog2(DEVSEL_TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_TURN = 3'd4;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_MABORT = 2'b01;
  localparam logic [1:0] ST_TABORT = 2'b10;
  localparam logic [1:0] ST_RETRY  = 2'b11;

  logic [2:0]     state_q, state_d;
  logic           write_q, write_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     be_q, be_d;
  logic [RCW-1:0] retry_cnt_q, retry_cnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           dsel_seen_q, dsel_seen_d;
  logic           again_q, again_d;

  logic           reqn_q, reqn_d;
  logic           framen_q, framen_d;
  logic           irdyn_q, irdyn_d;
  logic           ctloe_q, ctloe_d;
  logic [31:0]    ad_q, ad_d;
  logic           adoe_q, adoe_d;
  logic [3:0]     cbe_q, cbe_d;
  logic           cbeoe_q, cbeoe_d;
  logic           par_q, par_d;
  logic           paroe_q, paroe_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]     rsp_status_q, rsp_status_d;

  // State and registered bus/local outputs; reset drops every enable at once.
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      retry_cnt_q  <= '0;
      dcnt_q       <= '0;
      dsel_seen_q  <= 1'b0;
      again_q      <= 1'b0;
      reqn_q       <= 1'b1;
      framen_q     <= 1'b1;
      irdyn_q      <= 1'b1;
      ctloe_q      <= 1'b0;
      ad_q         <= '0;
      adoe_q       <= 1'b0;
      cbe_q        <= 4'hF;
      cbeoe_q      <= 1'b0;
      par_q        <= 1'b0;
      paroe_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      retry_cnt_q  <= retry_cnt_d;
      dcnt_q       <= dcnt_d;
      dsel_seen_q  <= dsel_seen_d;
      again_q      <= again_d;
      reqn_q       <= reqn_d;
      framen_q     <= framen_d;
      irdyn_q      <= irdyn_d;
      ctloe_q      <= ctloe_d;
      ad_q         <= ad_d;
      adoe_q       <= adoe_d;
      cbe_q        <= cbe_d;
      cbeoe_q      <= cbeoe_d;
      par_q        <= par_d;
      paroe_q      <= paroe_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Next state, then outputs decoded from the state being entered.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    retry_cnt_d  = retry_cnt_q;
    dcnt_d       = dcnt_q;
    dsel_seen_d  = dsel_seen_q;
    again_d      = again_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          retry_cnt_d = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (!PCI_GNTn && PCI_FRAMEn_i && PCI_IRDYn_i) state_d = S_ADDR;
      end
      S_ADDR: begin
        dcnt_d      = '0;
        dsel_seen_d = 1'b0;
        state_d     = S_DATA;
      end
      S_DATA: begin
        if (!PCI_DEVSELn) dsel_seen_d = 1'b1;
        if (!PCI_DEVSELn && !PCI_TRDYn) begin
          state_d      = S_TURN;
          again_d      = 1'b0;
          rsp_status_d = ST_OK;
          if (!write_q) rsp_rdata_d = PCI_AD_i;
        end else if (!PCI_STOPn && PCI_DEVSELn) begin
          state_d      = S_TURN;
          again_d      = 1'b0;
          rsp_status_d = ST_TABORT;
        end else if (!PCI_STOPn) begin
          // Retries already tolerated are counted before this one.
          state_d = S_TURN;
          if (retry_cnt_q == RCW'(MAX_RETRY)) begin
            again_d      = 1'b0;
            rsp_status_d = ST_RETRY;
          end else begin
            again_d     = 1'b1;
            retry_cnt_d = retry_cnt_q + RCW'(1);
          end
        end else if (PCI_DEVSELn && !dsel_seen_q && dcnt_q == DCW'(DEVSEL_TIMEOUT - 1)) begin
          state_d      = S_TURN;
          again_d      = 1'b0;
          rsp_status_d = ST_MABORT;
        end else if (!dsel_seen_d) begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      S_TURN: begin
        state_d = again_q ? S_REQ : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    reqn_d      = 1'b1;
    framen_d    = 1'b1;
    irdyn_d     = 1'b1;
    ctloe_d     = 1'b0;
    ad_d        = ad_q;
    adoe_d      = 1'b0;
    cbe_d       = cbe_q;
    cbeoe_d     = 1'b0;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    par_d       = ^{ad_q, cbe_q};
    paroe_d     = adoe_q;

    case (state_d)
      S_IDLE: req_ready_d = 1'b1;
      S_REQ:  reqn_d = 1'b0;
      S_ADDR: begin
        framen_d = 1'b0;
        ctloe_d  = 1'b1;
        ad_d     = addr_q & 32'hFFFF_FFFC;
        adoe_d   = 1'b1;
        cbe_d    = write_q ? CMD_MEM_WRITE : CMD_MEM_READ;
        cbeoe_d  = 1'b1;
      end
      S_DATA: begin
        irdyn_d = 1'b0;
        ctloe_d = 1'b1;
        cbe_d   = ~be_q;
        cbeoe_d = 1'b1;
        adoe_d  = write_q;
        if (write_q) ad_d = wdata_q;
      end
      S_TURN: begin
        ctloe_d     = 1'b1;
        rsp_valid_d = !again_d;
      end
      default: begin
        req_ready_d = 1'b0;
      end
    endcase
  end

  assign PCI_REQn     = reqn_q;
  assign PCI_FRAMEn_o = framen_q;
  assign PCI_IRDYn_o  = irdyn_q;
  assign PCI_CTLoe    = ctloe_q;
  assign PCI_AD_o     = ad_q;
  assign PCI_ADoe     = adoe_q;
  assign PCI_CBE_o    = cbe_q;
  assign PCI_CBEoe    = cbeoe_q;
  assign PCI_PAR_o    = par_q;
  assign PCI_PARoe    = paroe_q;
  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_status   = rsp_status_q;

endmodule

// File: tb/tb_pci_single_initiator.sv
// Bench for pci_single_initiator: behavioural arbiter and memory target, a directed
// table, randomized transactions against a reference model, and reset corner cases.
module tb_pci_single_initiator;

  localparam int unsigned TB_MAX_RETRY = 3;
  localparam int unsigned TB_TIMEOUT   = 5;

  logic        PCI_CLK, PCI_RSTn, PCI_REQn, PCI_GNTn;
  logic        PCI_FRAMEn_i, PCI_IRDYn_i, PCI_FRAMEn_o, PCI_IRDYn_o, PCI_CTLoe;
  logic        PCI_TRDYn, PCI_STOPn, PCI_DEVSELn;
  logic [31:0] PCI_AD_i, PCI_AD_o;
  logic        PCI_ADoe, PCI_CBEoe, PCI_PAR_o, PCI_PARoe;
  logic [3:0]  PCI_CBE_o;
  logic        req_valid, req_write, req_ready, rsp_valid;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic [1:0]  rsp_status;
  logic        bus_busy;

  pci_single_initiator #(.MAX_RETRY(TB_MAX_RETRY), .DEVSEL_TIMEOUT(TB_TIMEOUT)) dut (
    .PCI_CLK(PCI_CLK), .PCI_RSTn(PCI_RSTn), .PCI_REQn(PCI_REQn), .PCI_GNTn(PCI_GNTn),
    .PCI_FRAMEn_i(PCI_FRAMEn_i), .PCI_IRDYn_i(PCI_IRDYn_i),
    .PCI_FRAMEn_o(PCI_FRAMEn_o), .PCI_IRDYn_o(PCI_IRDYn_o), .PCI_CTLoe(PCI_CTLoe),
    .PCI_TRDYn(PCI_TRDYn), .PCI_STOPn(PCI_STOPn), .PCI_DEVSELn(PCI_DEVSELn),
    .PCI_AD_i(PCI_AD_i), .PCI_AD_o(PCI_AD_o), .PCI_ADoe(PCI_ADoe),
    .PCI_CBE_o(PCI_CBE_o), .PCI_CBEoe(PCI_CBEoe), .PCI_PAR_o(PCI_PAR_o), .PCI_PARoe(PCI_PARoe),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status)
  );

  initial PCI_CLK = 1'b0;
  always #5 PCI_CLK = ~PCI_CLK;

  // Bus idle view: our own driven values when enabled, otherwise another master may be busy.
  assign PCI_FRAMEn_i = PCI_CTLoe ? PCI_FRAMEn_o : ~bus_busy;
  assign PCI_IRDYn_i  = PCI_CTLoe ? PCI_IRDYn_o  : ~bus_busy;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Arbiter: grants a pending request most cycles, occasionally withdraws it.
  always @(negedge PCI_CLK) begin
    PCI_GNTn = !(!PCI_REQn && ($urandom_range(0, 3) != 0));
    bus_busy = ($urandom_range(0, 7) == 0);
  end

  // Memory target: decodes addr[31]=1, configurable DEVSEL delay, waits, retries, abort.
  logic [31:0] tgt_mem [logic [31:0]];
  int          tgt_retries, tgt_dly, tgt_waits;
  bit          tgt_tabort;
  logic [31:0] t_addr;
  bit          t_wr;
  int          t_k;

  always @(negedge PCI_CLK) begin
    logic [31:0] w;
    PCI_DEVSELn = 1'b1;
    PCI_TRDYn   = 1'b1;
    PCI_STOPn   = 1'b1;
    PCI_AD_i    = $urandom;
    if (PCI_CTLoe && !PCI_FRAMEn_o) begin
      t_addr = PCI_AD_o;
      t_wr   = (PCI_CBE_o == 4'h7);
      t_k    = 0;
    end else if (PCI_CTLoe && !PCI_IRDYn_o) begin
      if (t_addr[31] && t_k >= tgt_dly) begin
        if (tgt_tabort) PCI_STOPn = 1'b0;
        else begin
          PCI_DEVSELn = 1'b0;
          if (t_k >= tgt_dly + tgt_waits) begin
            if (tgt_retries > 0) begin
              PCI_STOPn = 1'b0;
              tgt_retries--;
            end else begin
              PCI_TRDYn = 1'b0;
              w = tgt_mem.exists(t_addr) ? tgt_mem[t_addr] : default_word(t_addr);
              if (t_wr) begin
                for (int b = 0; b < 4; b++)
                  if (!PCI_CBE_o[b]) w[8*b +: 8] = PCI_AD_o[8*b +: 8];
                tgt_mem[t_addr] = w;
              end else PCI_AD_i = w;
            end
          end
        end
      end
      t_k++;
    end
  end

  // Bus monitor: phase counts and captures of the last address/data phase.
  int          addr_phases = 0, req_asserts = 0, rsp_cnt = 0, data_cyc = 0, since = 99;
  logic        req_prev = 1'b1;
  logic [31:0] cap_addr_ad, cap_data_ad;
  logic [3:0]  cap_addr_cbe, cap_data_cbe;
  logic        cap_data_adoe, cap_par1, cap_paroe1, cap_par2, cap_paroe2;

  always @(negedge PCI_CLK) begin
    if (PCI_CTLoe && !PCI_FRAMEn_o) begin
      addr_phases++;
      cap_addr_ad  = PCI_AD_o;
      cap_addr_cbe = PCI_CBE_o;
      data_cyc     = 0;
      since        = 0;
    end else begin
      since++;
      if (PCI_CTLoe && !PCI_IRDYn_o) begin
        data_cyc++;
        cap_data_ad   = PCI_AD_o;
        cap_data_cbe  = PCI_CBE_o;
        cap_data_adoe = PCI_ADoe;
      end
      if (since == 1) begin cap_par1 = PCI_PAR_o; cap_paroe1 = PCI_PARoe; end
      if (since == 2) begin cap_par2 = PCI_PAR_o; cap_paroe2 = PCI_PARoe; end
    end
    if (!PCI_REQn && req_prev) req_asserts++;
    req_prev = PCI_REQn;
    if (rsp_valid) rsp_cnt++;
  end

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          retries;
    bit          tabort;
    int          dly;
    int          waits;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    int          exp_att;
    int          exp_cyc;
  } txn_t;

  function automatic txn_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be, int r,
                              bit ta, int dl, int wt, logic [1:0] st, logic [31:0] rd, int att, int cyc);
    txn_t t;
    t.write = wr; t.addr = a; t.wdata = d; t.be = be; t.retries = r; t.tabort = ta;
    t.dly = dl; t.waits = wt; t.exp_st = st; t.exp_rd = rd; t.exp_att = att; t.exp_cyc = cyc;
    return t;
  endfunction

  // Reference model: outcome follows from target behaviour and retry budget alone.
  logic [31:0] ref_mem [logic [31:0]];

  task automatic model(inout txn_t t);
    logic [31:0] a, w;
    a = t.addr & 32'hFFFF_FFFC;
    t.exp_rd = 32'h0;
    if (!t.addr[31]) begin
      t.exp_st = 2'b01; t.exp_att = 1; t.exp_cyc = TB_TIMEOUT;
    end else if (t.tabort) begin
      t.exp_st = 2'b10; t.exp_att = 1; t.exp_cyc = t.dly + 1;
    end else if (t.retries > TB_MAX_RETRY) begin
      t.exp_st = 2'b11; t.exp_att = TB_MAX_RETRY + 1; t.exp_cyc = t.dly + t.waits + 1;
    end else begin
      t.exp_st = 2'b00; t.exp_att = t.retries + 1; t.exp_cyc = t.dly + t.waits + 1;
      w = ref_mem.exists(a) ? ref_mem[a] : default_word(a);
      if (t.write) begin
        for (int b = 0; b < 4; b++) if (t.be[b]) w[8*b +: 8] = t.wdata[8*b +: 8];
        ref_mem[a] = w;
      end else t.exp_rd = w;
    end
  endtask

  task automatic issue(input txn_t t, input bit hold);
    tgt_retries = t.retries; tgt_tabort = t.tabort; tgt_dly = t.dly; tgt_waits = t.waits;
    @(negedge PCI_CLK);
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge PCI_CLK);
    req_write = t.write; req_addr = t.addr; req_wdata = t.wdata; req_be = t.be; req_valid = 1'b1;
    @(negedge PCI_CLK);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic run_txn(input txn_t t, input string tag, input bit hold);
    int  a0, r0;
    bit  got;
    a0 = addr_phases; r0 = req_asserts;
    issue(t, hold);
    got = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      if (rsp_valid) got = 1; else @(negedge PCI_CLK);
    end
    req_valid = 1'b0;
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    check({tag, " status"}, 32'(rsp_status), 32'(t.exp_st));
    check({tag, " attempts"}, 32'(addr_phases - a0), 32'(t.exp_att));
    check({tag, " req_asserts"}, 32'(req_asserts - r0), 32'(t.exp_att));
    check({tag, " data_cycles"}, 32'(data_cyc), 32'(t.exp_cyc));
    if (!t.write && t.exp_st == 2'b00) check({tag, " rdata"}, rsp_rdata, t.exp_rd);
    check({tag, " turn_ctl"}, 32'({PCI_CTLoe, PCI_ADoe, PCI_CBEoe, PCI_FRAMEn_o, PCI_IRDYn_o}), 32'(5'b10011));
    @(negedge PCI_CLK);
    check({tag, " rsp_one_cycle"}, 32'({rsp_valid, PCI_CTLoe}), 32'd0);
  endtask

  txn_t tbl [11];

  initial begin
    logic [35:0] pv;
    txn_t t;
    int   r0, a0;
    bit   got;

    PCI_RSTn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    PCI_GNTn = 1'b1; bus_busy = 1'b0; PCI_DEVSELn = 1'b1; PCI_TRDYn = 1'b1; PCI_STOPn = 1'b1;
    PCI_AD_i = '0; tgt_retries = 0; tgt_dly = 0; tgt_waits = 0; tgt_tabort = 0;

    tbl[0]  = mk(1, 32'h8000_0010, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 1, 1);
    tbl[1]  = mk(0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 32'hA5A5_1234, 1, 1);
    tbl[2]  = mk(1, 32'h8000_0020, 32'h1111_2222, 4'hF, 3, 0, 0, 0, 2'b00, 32'h0, 4, 1);
    tbl[3]  = mk(0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 0, 0, 2'b01, 32'h0, 1, 5);
    tbl[4]  = mk(1, 32'h8000_0030, 32'h3333_3333, 4'hF, 0, 1, 0, 0, 2'b10, 32'h0, 1, 1);
    tbl[5]  = mk(0, 32'h8000_0040, 32'h0, 4'hF, 99, 0, 0, 0, 2'b11, 32'h0, 4, 1);
    tbl[6]  = mk(1, 32'h8000_0010, 32'hFFFF_0000, 4'h5, 0, 0, 0, 1, 2'b00, 32'h0, 1, 2);
    tbl[7]  = mk(0, 32'h8000_0013, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 32'hA5FF_1200, 1, 1);
    tbl[8]  = mk(0, 32'h8000_0050, 32'h0, 4'hF, 0, 0, 4, 0, 2'b00, 32'h5EAD_BEBF, 1, 5);
    tbl[9]  = mk(0, 32'h8000_0020, 32'h0, 4'hF, 0, 0, 1, 2, 2'b00, 32'h1111_2222, 1, 4);
    tbl[10] = mk(1, 32'h8000_0060, 32'h0, 4'hF, 0, 1, 4, 0, 2'b10, 32'h0, 1, 5);

    repeat (3) @(negedge PCI_CLK);
    check("rst enables", 32'({PCI_CTLoe, PCI_ADoe, PCI_CBEoe, PCI_PARoe}), 32'd0);
    check("rst ctl", 32'({PCI_REQn, PCI_FRAMEn_o, PCI_IRDYn_o}), 32'(3'b111));
    check("rst ad", PCI_AD_o, 32'h0);
    check("rst cbe_par", 32'({PCI_CBE_o, PCI_PAR_o}), 32'(5'b11110));
    check("rst local", 32'({req_ready, rsp_valid, rsp_status}), 32'(4'b1000));
    check("rst rdata", rsp_rdata, 32'h0);
    PCI_RSTn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i), 1'b0);
      if (i == 0) begin
        check("w addr_ad", cap_addr_ad, 32'h8000_0010);
        check("w addr_cbe", 32'(cap_addr_cbe), 32'h7);
        check("w data_cbe", 32'(cap_data_cbe), 32'h0);
        check("w data_ad", cap_data_ad, 32'hA5A5_1234);
        pv = {32'h8000_0010, 4'h7};
        check("w addr_par", 32'({cap_par1, cap_paroe1}), 32'({^pv, 1'b1}));
        pv = {32'hA5A5_1234, 4'h0};
        check("w data_par", 32'({cap_par2, cap_paroe2}), 32'({^pv, 1'b1}));
      end
      if (i == 1) begin
        check("r data_adoe", 32'(cap_data_adoe), 32'd0);
        check("r addr_cbe", 32'(cap_addr_cbe), 32'h6);
        check("r paroe1", 32'(cap_paroe1), 32'd1);
        check("r paroe2", 32'(cap_paroe2), 32'd0);
      end
    end

    // req_valid held high through a whole transaction must not start a second one.
    a0 = addr_phases; r0 = rsp_cnt;
    t = mk(1, 32'h8000_0070, 32'h7777_7777, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 1, 1);
    run_txn(t, "hold", 1'b1);
    repeat (4) @(negedge PCI_CLK);
    check("hold addr_phases", 32'(addr_phases - a0), 32'd1);
    check("hold rsp_cnt", 32'(rsp_cnt - r0), 32'd1);

    for (int i = 0; i < 30; i++) begin
      t.write   = $urandom_range(0, 1);
      t.addr    = ($urandom_range(0, 7) == 0) ? 32'h1000_0000 : 32'h8000_1000 + 32'($urandom_range(0, 7) * 4);
      t.addr    = t.addr | 32'($urandom_range(0, 3));
      t.wdata   = $urandom;
      t.be      = 4'($urandom_range(0, 15));
      t.retries = $urandom_range(0, TB_MAX_RETRY + 1);
      t.tabort  = ($urandom_range(0, 7) == 0);
      t.dly     = $urandom_range(0, TB_TIMEOUT - 1);
      t.waits   = $urandom_range(0, 2);
      model(t);
      run_txn(t, $sformatf("rnd%0d", i), 1'b0);
    end

    // Reset during the data phase: enables drop at once and no response follows.
    r0 = rsp_cnt;
    t = mk(1, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 0, 0, 2'b01, 32'h0, 1, 5);
    issue(t, 1'b0);
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (PCI_CTLoe && !PCI_IRDYn_o) got = 1; else @(negedge PCI_CLK);
    end
    check("mid reset reached data", 32'(got), 32'd1);
    #2 PCI_RSTn = 1'b0;
    #1;
    check("mid reset enables", 32'({PCI_CTLoe, PCI_ADoe, PCI_CBEoe, PCI_PARoe}), 32'd0);
    check("mid reset ctl", 32'({PCI_REQn, PCI_FRAMEn_o, PCI_IRDYn_o}), 32'(3'b111));
    repeat (2) @(negedge PCI_CLK);
    PCI_RSTn = 1'b1;
    repeat (20) @(negedge PCI_CLK);
    check("mid reset no rsp", 32'(rsp_cnt - r0), 32'd0);
    check("mid reset idle", 32'({req_ready, PCI_REQn, PCI_CTLoe}), 32'(3'b110));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
